argon_datapath: RTL and testbench

Execution datapath of the Argon multi-cycle CPU: a 32×32-bit register file (two read ports, one write port) plus a 16-operation 32-bit ALU with a registered result and equality flags. The control FSM drives register selects, write data, ALU operands and opcode, and consumes read data, ALU result and flags. Scope is the register file and ALU pair only. There is no sequencing logic.

---
 rtl/argon_datapath_if.sv | 30 +++
 rtl/argon_datapath.sv | 112 +++++++++++
 tb/tb_argon_datapath.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/argon_datapath_if.sv
// Bus between the Argon control FSM and the execution datapath.
// The master drives selects, write data and ALU operands; the slave returns read data, result and flags.
interface argon_datapath_if;
  logic        i_write_en;
  logic [4:0]  i_selectA;
  logic [4:0]  i_selectB;
  logic [4:0]  i_selectW;
  logic [31:0] i_portW;
  logic [31:0] o_portA;
  logic [31:0] o_portB;
  logic [3:0]  i_opcode;
  logic [4:0]  i_shamt;
  logic [31:0] i_wordA;
  logic [31:0] i_wordB;
  logic [31:0] o_result;
  logic        o_flag_equal;
  logic        o_flag_notequal;

  modport master (
    output i_write_en, i_selectA, i_selectB, i_selectW, i_portW,
    output i_opcode, i_shamt, i_wordA, i_wordB,
    input  o_portA, o_portB, o_result, o_flag_equal, o_flag_notequal
  );

  modport slave (
    input  i_write_en, i_selectA, i_selectB, i_selectW, i_portW,
    input  i_opcode, i_shamt, i_wordA, i_wordB,
    output o_portA, o_portB, o_result, o_flag_equal, o_flag_notequal
  );
endinterface

// File: rtl/argon_datapath.sv
// Argon execution datapath: 32x32 register file (2R/1W, r0 hardwired to zero)
// and a 16-operation ALU with a registered result and equality flags.
module argon_datapath (
  input logic             i_clk,
  input logic             i_reset,
  argon_datapath_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_NOR  = 4'd4,
    OP_XOR  = 4'd5,
    OP_SETB = 4'd6,
    OP_CLRB = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_SLLV = 4'd11,
    OP_SRLV = 4'd12,
    OP_SRAV = 4'd13,
    OP_SLT  = 4'd14,
    OP_SLTU = 4'd15
  } alu_op_e;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] result_q;
  logic [31:0] result_d;
  logic        flag_equal_q;
  logic        flag_equal_d;

  // Register file: no bypass, so reads always see the pre-edge contents.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (bus.i_write_en) begin
      regs_d[bus.i_selectW] = bus.i_portW;
    end
    regs_d[0] = 32'd0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign bus.o_portA = regs_q[bus.i_selectA];
  assign bus.o_portB = regs_q[bus.i_selectB];

  logic [31:0] word_a;
  logic [31:0] word_b;
  logic [4:0]  var_shamt;
  logic [31:0] bit_mask;
  alu_op_e     opcode;

  assign word_a    = bus.i_wordA;
  assign word_b    = bus.i_wordB;
  assign var_shamt = bus.i_wordB[4:0];
  assign bit_mask  = 32'd1 << var_shamt;
  assign opcode    = alu_op_e'(bus.i_opcode);

  always_comb begin
    result_d     = 32'd0;
    flag_equal_d = (word_a == word_b);
    unique case (opcode)
      OP_ADD:  result_d = word_a + word_b;
      OP_SUB:  result_d = word_a - word_b;
      OP_AND:  result_d = word_a & word_b;
      OP_OR:   result_d = word_a | word_b;
      OP_NOR:  result_d = ~(word_a | word_b);
      OP_XOR:  result_d = word_a ^ word_b;
      OP_SETB: result_d = word_a | bit_mask;
      OP_CLRB: result_d = word_a & ~bit_mask;
      OP_SLL:  result_d = word_a << bus.i_shamt;
      OP_SRL:  result_d = word_a >> bus.i_shamt;
      OP_SRA:  result_d = $unsigned($signed(word_a) >>> bus.i_shamt);
      OP_SLLV: result_d = word_a << var_shamt;
      OP_SRLV: result_d = word_a >> var_shamt;
      OP_SRAV: result_d = $unsigned($signed(word_a) >>> var_shamt);
      OP_SLT:  result_d = {31'd0, ($signed(word_a) < $signed(word_b))};
      OP_SLTU: result_d = {31'd0, (word_a < word_b)};
      default: result_d = 32'd0;
    endcase
  end

  // Reset values describe "0 == 0": result zero, operands equal.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      result_q     <= 32'd0;
      flag_equal_q <= 1'b1;
    end else begin
      result_q     <= result_d;
      flag_equal_q <= flag_equal_d;
    end
  end

  assign bus.o_result        = result_q;
  assign bus.o_flag_equal    = flag_equal_q;
  assign bus.o_flag_notequal = ~flag_equal_q;

endmodule

// File: tb/tb_argon_datapath.sv
// Self-checking bench for argon_datapath: register file read/write/reset and
// ALU results with a queue of expected outputs matched one edge later.
module tb_argon_datapath;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  argon_datapath_if bus ();

  argon_datapath dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        eq;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] shadow [32];
  logic [31:0] last_res;
  logic        last_eq;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Drives one operation at the falling edge, checks the outputs still hold the
  // previous answer, then checks the new answer just after the rising edge.
  task automatic alu_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] res);
    exp_t e;
    @(negedge clk);
    bus.i_opcode = op;
    bus.i_wordA  = a;
    bus.i_wordB  = b;
    bus.i_shamt  = sh;
    e.res = res;
    e.eq  = (a == b);
    exp_q.push_back(e);
    #1;
    check_val($sformatf("hold_op%0d", op), bus.o_result, last_res);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty got=0 exp=1");
    end else begin
      e = exp_q.pop_front();
      check_val($sformatf("result_op%0d", op), bus.o_result, e.res);
      check_val($sformatf("eq_op%0d", op), {31'd0, bus.o_flag_equal}, {31'd0, e.eq});
      check_val($sformatf("ne_op%0d", op), {31'd0, bus.o_flag_notequal}, {31'd0, ~e.eq});
      last_res = e.res;
      last_eq  = e.eq;
    end
  endtask

  task automatic reg_write(input logic [4:0] sel, input logic [31:0] data);
    @(negedge clk);
    bus.i_write_en = 1'b1;
    bus.i_selectW  = sel;
    bus.i_portW    = data;
    @(posedge clk);
    #1;
    if (sel != 5'd0) shadow[sel] = data;
    @(negedge clk);
    bus.i_write_en = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb, rr;
    logic [3:0]  rop;
    logic [4:0]  rs;

    rst            = 1'b1;
    bus.i_write_en = 1'b1;
    bus.i_selectA  = 5'd5;
    bus.i_selectB  = 5'd0;
    bus.i_selectW  = 5'd5;
    bus.i_portW    = 32'hAAAA_5555;
    bus.i_opcode   = 4'd0;
    bus.i_shamt    = 5'd0;
    bus.i_wordA    = 32'd0;
    bus.i_wordB    = 32'd0;
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    last_res = 32'd0;
    last_eq  = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst            = 1'b0;
    bus.i_write_en = 1'b0;

    for (int i = 0; i < 32; i++) begin
      bus.i_selectA = i[4:0];
      bus.i_selectB = 5'(31 - i);
      #1;
      check_val($sformatf("reset_rA%0d", i), bus.o_portA, 32'd0);
      check_val($sformatf("reset_rB%0d", 31 - i), bus.o_portB, 32'd0);
    end
    #1;
    check_val("reset_result", bus.o_result, 32'd0);
    check_val("reset_eq", {31'd0, bus.o_flag_equal}, 32'd1);
    check_val("reset_ne", {31'd0, bus.o_flag_notequal}, 32'd0);

    // Old data before the capturing edge, new data after it.
    @(negedge clk);
    bus.i_selectA  = 5'd5;
    bus.i_selectB  = 5'd0;
    bus.i_write_en = 1'b1;
    bus.i_selectW  = 5'd5;
    bus.i_portW    = 32'hDEAD_BEEF;
    #1;
    check_val("pre_write_r5", bus.o_portA, 32'd0);
    @(posedge clk);
    #1;
    check_val("post_write_r5", bus.o_portA, 32'hDEAD_BEEF);
    shadow[5] = 32'hDEAD_BEEF;
    reg_write(5'd0, 32'h1234_5678);
    #1;
    check_val("r0_after_write", bus.o_portB, 32'd0);
    check_val("r5_kept", bus.o_portA, 32'hDEAD_BEEF);

    for (int i = 0; i < 6; i++) begin
      reg_write(5'($urandom_range(1, 31)), $urandom);
    end
    for (int i = 0; i < 32; i++) begin
      bus.i_selectA = i[4:0];
      bus.i_selectB = i[4:0];
      #1;
      check_val($sformatf("rd_A%0d", i), bus.o_portA, shadow[i]);
      check_val($sformatf("rd_B%0d", i), bus.o_portB, shadow[i]);
    end

    alu_op(4'd0,  32'h7FFF_FFFF, 32'h1,         5'd0, 32'h8000_0000);
    alu_op(4'd1,  32'h7FFF_FFFF, 32'h1,         5'd0, 32'h7FFF_FFFE);
    alu_op(4'd14, 32'h8000_0000, 32'h1,         5'd0, 32'h1);
    alu_op(4'd15, 32'h8000_0000, 32'h1,         5'd0, 32'h0);
    alu_op(4'd8,  32'h8000_0010, 32'h0,         5'd4, 32'h0000_0100);
    alu_op(4'd9,  32'h8000_0010, 32'h0,         5'd4, 32'h0800_0001);
    alu_op(4'd10, 32'h8000_0010, 32'h0,         5'd4, 32'hF800_0001);
    alu_op(4'd11, 32'h8000_0010, 32'h24,        5'd0, 32'h0000_0100);
    alu_op(4'd12, 32'h8000_0010, 32'hFFFF_FFE4, 5'd0, 32'h0800_0001);
    alu_op(4'd13, 32'h8000_0010, 32'h44,        5'd0, 32'hF800_0001);
    alu_op(4'd6,  32'h0000_000F, 32'h4,         5'd0, 32'h0000_001F);
    alu_op(4'd7,  32'h0000_000F, 32'h3,         5'd0, 32'h0000_0007);
    alu_op(4'd4,  32'h0000_000F, 32'hF0,        5'd0, 32'hFFFF_FF00);
    alu_op(4'd5,  32'h0000_000F, 32'hFF,        5'd0, 32'h0000_00F0);
    alu_op(4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200);
    alu_op(4'd3,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'hFFF0_FF34);
    alu_op(4'd14, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 32'h0);
    alu_op(4'd15, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 32'h1);
    alu_op(4'd8,  32'h0000_0001, 32'h0,         5'd31, 32'h8000_0000);
    alu_op(4'd0,  32'h55,        32'h55,        5'd0, 32'hAA);
    alu_op(4'd1,  32'h55,        32'h56,        5'd0, 32'hFFFF_FFFF);

    for (int i = 0; i < 12; i++) begin
      ra  = $urandom;
      rb  = (i % 4 == 0) ? ra : $urandom;
      rs  = 5'($urandom_range(0, 31));
      rop = 4'($urandom_range(0, 3));
      case (rop)
        4'd0:    begin rop = 4'd0;  rr = ra + rb; end
        4'd1:    begin rop = 4'd1;  rr = ra - rb; end
        4'd2:    begin rop = 4'd10; rr = ra; for (int k = 0; k < 32; k++) if (k < rs) rr = {rr[31], rr[31:1]}; end
        default: begin rop = 4'd15; rr = (ra < rb) ? 32'd1 : 32'd0; end
      endcase
      alu_op(rop, ra, rb, rs, rr);
    end

    // Reset with an operation in flight and a write pending.
    @(negedge clk);
    bus.i_opcode   = 4'd0;
    bus.i_wordA    = 32'h1;
    bus.i_wordB    = 32'h2;
    bus.i_write_en = 1'b1;
    bus.i_selectW  = 5'd7;
    bus.i_portW    = 32'hCAFE_F00D;
    bus.i_selectA  = 5'd5;
    bus.i_selectB  = 5'd7;
    rst            = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst_result", bus.o_result, 32'd0);
    check_val("midrst_eq", {31'd0, bus.o_flag_equal}, 32'd1);
    check_val("midrst_ne", {31'd0, bus.o_flag_notequal}, 32'd0);
    check_val("midrst_r5", bus.o_portA, 32'd0);
    check_val("midrst_r7", bus.o_portB, 32'd0);
    @(negedge clk);
    rst            = 1'b0;
    bus.i_write_en = 1'b0;

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
